// File: rtl/juggle_pkg.sv
// rtl/juggle_pkg.sv - shared constants, types and helpers for the throw scheduler
package juggle_pkg;

  localparam int MAX_BALLS  = 7;
  localparam int MAX_PERIOD = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CFG  = 2'd1;
  localparam logic [1:0] ERR_AVG  = 2'd2;
  localparam logic [1:0] ERR_COLL = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [2:0] ball;
  } qslot_t;

  // Landing slot of element idx within the pattern period; len of 0 never reaches CHECK.
  function automatic logic [2:0] land_slot(input logic [2:0] idx, input logic [2:0] h,
                                           input logic [2:0] len);
    logic [3:0] s;
    s = {1'b0, idx} + {1'b0, h};
    if (len == 3'd0) return 3'd0;
    return 3'(s % {1'b0, len});
  endfunction

endpackage

// File: rtl/throw_scheduler_if.sv
// rtl/throw_scheduler_if.sv - config, control and throw-event bundle of the scheduler
interface throw_scheduler_if
  import juggle_pkg::*;
#(
  parameter int T_W = 32
);
  logic [3*MAX_PERIOD-1:0] pattern;
  logic [2:0]              pattern_len;
  logic [2:0]              num_balls;
  logic [T_W-1:0]          cyc_per_beat;
  logic                    start;
  logic                    stop;
  logic                    beat_tick;
  logic                    throw_valid;
  logic [2:0]              throw_ball;
  logic                    throw_hand;
  logic [2:0]              throw_height;
  logic [T_W-1:0]          t_now;
  logic                    busy;
  logic [1:0]              err;

  modport master (
    output pattern, pattern_len, num_balls, cyc_per_beat, start, stop,
    input  beat_tick, throw_valid, throw_ball, throw_hand, throw_height, t_now, busy, err
  );

  modport slave (
    input  pattern, pattern_len, num_balls, cyc_per_beat, start, stop,
    output beat_tick, throw_valid, throw_ball, throw_hand, throw_height, t_now, busy, err
  );
endinterface

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - modulo beat counter with one-cycle-ahead tick and run-time counter
module beat_timer #(
  parameter int T_W = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           clr,
  input  logic           en,
  input  logic [T_W-1:0] period,
  output logic           tick_next,
  output logic [T_W-1:0] t_now
);
  logic [T_W-1:0] cnt_q, cnt_d;
  logic [T_W-1:0] t_q, t_d;

  // Next counter values; tick_next flags that the coming cycle is a beat boundary.
  always_comb begin
    cnt_d     = cnt_q;
    t_d       = t_q;
    tick_next = 1'b0;
    if (clr) begin
      cnt_d     = '0;
      t_d       = '0;
      tick_next = 1'b1;
    end else if (en) begin
      t_d = t_q + T_W'(1);
      if (cnt_q == period - T_W'(1)) begin
        cnt_d     = '0;
        tick_next = 1'b1;
      end else begin
        cnt_d = cnt_q + T_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      t_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      t_q   <= t_d;
    end
  end

  assign t_now = t_q;
endmodule

// File: rtl/throw_scheduler.sv
// rtl/throw_scheduler.sv - siteswap validator and beat-rate throw event sequencer
module throw_scheduler
  import juggle_pkg::*;
#(
  parameter int T_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  throw_scheduler_if.slave bus
);
  state_t                  state_q, state_d;
  logic [3*MAX_PERIOD-1:0] pat_q, pat_d;
  logic [2:0]              len_q, len_d;
  logic [2:0]              nb_q, nb_d;
  logic [T_W-1:0]          cpb_q, cpb_d;
  logic [1:0]              err_q, err_d;
  logic [2:0]              chk_i_q, chk_i_d;
  logic [5:0]              sum_q, sum_d;
  logic [MAX_PERIOD-1:0]   mask_q, mask_d;
  logic                    coll_q, coll_d;
  logic                    coll_pend_q, coll_pend_d;
  qslot_t [MAX_BALLS-1:0]  queue_q, queue_d;
  logic [2:0]              pidx_q, pidx_d;
  logic                    hand_q, hand_d;
  logic                    beat_tick_q, beat_tick_d;
  logic                    throw_valid_q, throw_valid_d;
  logic [2:0]              throw_ball_q, throw_ball_d;
  logic                    throw_hand_q, throw_hand_d;
  logic [2:0]              throw_height_q, throw_height_d;

  logic                    timer_clr, timer_en, tick_next;
  logic [T_W-1:0]          t_now;

  logic [2:0]              chk_h, chk_slot, h, tgt, pidx_base;
  logic [5:0]              sum_fin;
  logic                    coll_fin, run_next, hand_base, bad;
  qslot_t [MAX_BALLS-1:0]  q_base, q_shift;

  // The timer is cleared throughout CHECK so RUN starts on a beat with t_now = 0.
  assign timer_clr = (state_q == ST_CHECK);
  assign timer_en  = (state_q == ST_RUN);

  beat_timer #(.T_W(T_W)) u_timer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr       (timer_clr),
    .en        (timer_en),
    .period    (cpb_q),
    .tick_next (tick_next),
    .t_now     (t_now)
  );

  // Next-state logic; beat events are computed one cycle ahead so the outputs are registered.
  always_comb begin
    state_d        = state_q;
    pat_d          = pat_q;
    len_d          = len_q;
    nb_d           = nb_q;
    cpb_d          = cpb_q;
    err_d          = err_q;
    chk_i_d        = chk_i_q;
    sum_d          = sum_q;
    mask_d         = mask_q;
    coll_d         = coll_q;
    coll_pend_d    = coll_pend_q;
    queue_d        = queue_q;
    pidx_d         = pidx_q;
    hand_d         = hand_q;
    beat_tick_d    = 1'b0;
    throw_valid_d  = 1'b0;
    throw_ball_d   = 3'd0;
    throw_hand_d   = 1'b0;
    throw_height_d = 3'd0;
    run_next       = 1'b0;

    chk_h    = pat_q[3*int'(chk_i_q) +: 3];
    chk_slot = land_slot(chk_i_q, chk_h, len_q);
    sum_fin  = sum_q + {3'd0, chk_h};
    coll_fin = coll_q | mask_q[chk_slot];

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pat_d       = bus.pattern;
          len_d       = bus.pattern_len;
          nb_d        = bus.num_balls;
          cpb_d       = bus.cyc_per_beat;
          chk_i_d     = 3'd0;
          sum_d       = 6'd0;
          mask_d      = '0;
          coll_d      = 1'b0;
          coll_pend_d = 1'b0;
          if (bus.pattern_len == 3'd0 || bus.num_balls == 3'd0 ||
              {1'b0, bus.num_balls} > 4'(MAX_BALLS) || bus.cyc_per_beat == '0) begin
            state_d = ST_ERROR;
            err_d   = ERR_CFG;
          end else begin
            state_d = ST_CHECK;
            err_d   = ERR_NONE;
          end
        end
      end
      ST_CHECK: begin
        sum_d            = sum_fin;
        coll_d           = coll_fin;
        mask_d[chk_slot] = 1'b1;
        chk_i_d          = chk_i_q + 3'd1;
        if (chk_i_q == len_q - 3'd1) begin
          if (coll_fin) begin
            state_d = ST_ERROR;
            err_d   = ERR_COLL;
          end else if (sum_fin != {3'd0, nb_q} * {3'd0, len_q}) begin
            state_d = ST_ERROR;
            err_d   = ERR_AVG;
          end else begin
            state_d  = ST_RUN;
            run_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (coll_pend_q) begin
          state_d     = ST_ERROR;
          err_d       = ERR_COLL;
          coll_pend_d = 1'b0;
        end else begin
          run_next = 1'b1;
        end
      end
      ST_ERROR: begin
        if (bus.stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // On RUN entry the queue starts from the ground state: ball k in slot k.
    for (int k = 0; k < MAX_BALLS; k++) begin
      if (state_q == ST_CHECK) q_base[k] = qslot_t'{valid: (3'(k) < nb_q), ball: 3'(k)};
      else                     q_base[k] = queue_q[k];
    end
    for (int k = 0; k < MAX_BALLS - 1; k++) q_shift[k] = q_base[k+1];
    q_shift[MAX_BALLS-1] = '0;

    pidx_base = (state_q == ST_CHECK) ? 3'd0 : pidx_q;
    hand_base = (state_q == ST_CHECK) ? 1'b0 : hand_q;
    h         = pat_q[3*int'(pidx_base) +: 3];
    tgt       = h - 3'd1;
    bad       = ((h != 3'd0) && !q_base[0].valid) || ((h == 3'd0) && q_base[0].valid) ||
                ((h != 3'd0) && q_shift[tgt].valid);

    if (run_next && tick_next) begin
      beat_tick_d = 1'b1;
      if (bad) begin
        coll_pend_d = 1'b1;
      end else begin
        queue_d = q_shift;
        if (h != 3'd0) begin
          queue_d[tgt]   = qslot_t'{valid: 1'b1, ball: q_base[0].ball};
          throw_valid_d  = 1'b1;
          throw_ball_d   = q_base[0].ball;
          throw_hand_d   = hand_base;
          throw_height_d = h;
        end
        hand_d = ~hand_base;
        pidx_d = (pidx_base == len_q - 3'd1) ? 3'd0 : pidx_base + 3'd1;
      end
    end
  end

  // State, configuration, queue and registered event outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      pat_q          <= '0;
      len_q          <= 3'd0;
      nb_q           <= 3'd0;
      cpb_q          <= '0;
      err_q          <= ERR_NONE;
      chk_i_q        <= 3'd0;
      sum_q          <= 6'd0;
      mask_q         <= '0;
      coll_q         <= 1'b0;
      coll_pend_q    <= 1'b0;
      queue_q        <= '0;
      pidx_q         <= 3'd0;
      hand_q         <= 1'b0;
      beat_tick_q    <= 1'b0;
      throw_valid_q  <= 1'b0;
      throw_ball_q   <= 3'd0;
      throw_hand_q   <= 1'b0;
      throw_height_q <= 3'd0;
    end else begin
      state_q        <= state_d;
      pat_q          <= pat_d;
      len_q          <= len_d;
      nb_q           <= nb_d;
      cpb_q          <= cpb_d;
      err_q          <= err_d;
      chk_i_q        <= chk_i_d;
      sum_q          <= sum_d;
      mask_q         <= mask_d;
      coll_q         <= coll_d;
      coll_pend_q    <= coll_pend_d;
      queue_q        <= queue_d;
      pidx_q         <= pidx_d;
      hand_q         <= hand_d;
      beat_tick_q    <= beat_tick_d;
      throw_valid_q  <= throw_valid_d;
      throw_ball_q   <= throw_ball_d;
      throw_hand_q   <= throw_hand_d;
      throw_height_q <= throw_height_d;
    end
  end

  assign bus.beat_tick    = beat_tick_q;
  assign bus.throw_valid  = throw_valid_q;
  assign bus.throw_ball   = throw_ball_q;
  assign bus.throw_hand   = throw_hand_q;
  assign bus.throw_height = throw_height_q;
  assign bus.t_now        = t_now;
  assign bus.busy         = (state_q == ST_CHECK) || (state_q == ST_RUN);
  assign bus.err          = err_q;
endmodule
